// File: rtl/grant_decoder_4bit.sv
// Registered grant dispatcher: turns an encoded priority-encoder winner into a held one-hot grant,
// released on done, enable drop or timeout, with one release cycle before the next acceptance.
module grant_decoder_4bit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] idx,
  input  logic       noSig,
  input  logic [3:0] done,
  output logic [3:0] grant,
  output logic       busy,
  output logic       timeout,
  output logic       badIdx,
  output logic [7:0] grantCount
);

  typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

  localparam logic [7:0] TimerLast = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [7:0] timer_q, timer_d;
  logic [7:0] count_q, count_d;
  logic [3:0] grant_q, grant_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;
  logic       bad_idx_q, bad_idx_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      sel_q     <= 2'd0;
      timer_q   <= 8'd0;
      count_q   <= 8'd0;
      grant_q   <= 4'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      bad_idx_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      timer_q   <= timer_d;
      count_q   <= count_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      bad_idx_q <= bad_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    timer_d   = timer_q;
    count_d   = count_q;
    timeout_d = 1'b0;
    bad_idx_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable && !noSig) begin
          if (!idx[2]) begin
            state_d = StGrant;
            sel_d   = idx[1:0];
            timer_d = 8'd0;
          end else begin
            bad_idx_d = 1'b1;
          end
        end
      end
      StGrant: begin
        // Completion outranks abort, which outranks timer expiry.
        if (done[sel_q]) begin
          state_d = StRelease;
          count_d = count_q + 8'd1;
        end else if (!enable) begin
          state_d = StRelease;
        end else if (timer_q == TimerLast) begin
          state_d   = StRelease;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Registered outputs are derived from the state being entered.
  always_comb begin
    grant_d = 4'd0;
    busy_d  = (state_d != StIdle);
    if (state_d == StGrant) grant_d = 4'(4'b0001 << sel_d);
  end

  assign grant      = grant_q;
  assign busy       = busy_q;
  assign timeout    = timeout_q;
  assign badIdx     = bad_idx_q;
  assign grantCount = count_q;

endmodule
